// File: rtl/axi_pkg.sv
// axi_pkg: shared FSM state type, AXI3 field widths and encoding constants
package axi_pkg;

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0]  RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0]  RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI3 master driven by a command port and data streams
module axi_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic [RESP_W-1:0]     rd_resp,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic                  done_write,
    output logic [ID_W-1:0]       done_id,
    output logic [RESP_W-1:0]     done_resp,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [LEN_W-1:0]      awlen,
    output logic [SIZE_W-1:0]     awsize,
    output logic [BURST_W-1:0]    awburst,
    output logic [LOCK_W-1:0]     awlock,
    output logic [CACHE_W-1:0]    awcache,
    output logic [PROT_W-1:0]     awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [RESP_W-1:0]     bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [LEN_W-1:0]      arlen,
    output logic [SIZE_W-1:0]     arsize,
    output logic [BURST_W-1:0]    arburst,
    output logic [LOCK_W-1:0]     arlock,
    output logic [CACHE_W-1:0]    arcache,
    output logic [PROT_W-1:0]     arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [RESP_W-1:0]     rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [SIZE_W-1:0] AXSIZE = SIZE_W'($clog2(DATA_W/8));

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                cmd_ready_q, awvalid_q, arvalid_q, bready_q, done_valid_q;
    logic                in_w, in_r, last_beat;

    assign in_w      = state_q == WDATA;
    assign in_r      = state_q == RDATA;
    assign last_beat = cnt_q == len_q;

    assign cmd_ready  = cmd_ready_q;
    assign done_valid = done_valid_q;
    assign done_write = write_q;
    assign done_id    = id_q;
    assign done_resp  = resp_q;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXSIZE;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign awvalid = awvalid_q;

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXSIZE;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign arvalid = arvalid_q;

    assign wid      = id_q;
    assign wdata    = wr_data;
    assign wstrb    = wr_strb;
    assign wlast    = in_w && last_beat;
    assign wvalid   = in_w && wr_valid;
    assign wr_ready = in_w && wready;
    assign bready   = bready_q;

    assign rd_valid = in_r && rvalid;
    assign rready   = in_r && rd_ready;
    assign rd_data  = rdata;
    assign rd_resp  = rresp;
    assign rd_last  = rlast;

    // Sequencing of one transaction and capture of its fields and response
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d = cmd_write ? WADDR : RADDR;
                write_d = cmd_write;
                addr_d  = cmd_addr;
                id_d    = cmd_id;
                len_d   = cmd_len;
                cnt_d   = '0;
                resp_d  = RESP_OKAY;
            end
            WADDR: state_d = awready ? WDATA : WADDR;
            WDATA: if (wvalid && wready) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = last_beat ? WRESP : WDATA;
            end
            WRESP: if (bvalid) begin
                resp_d  = (bid != id_q) ? RESP_SLVERR : bresp;
                state_d = DONE;
            end
            RADDR: state_d = arready ? RDATA : RADDR;
            RDATA: if (rvalid && rready) begin
                cnt_d   = cnt_q + 1'b1;
                resp_d  = (rlast != last_beat || rid != id_q) ? RESP_SLVERR :
                          (rresp > resp_q) ? rresp : resp_q;
                state_d = (rlast || last_beat) ? DONE : RDATA;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched fields and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            id_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            resp_q       <= RESP_OKAY;
            cmd_ready_q  <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            cmd_ready_q  <= state_d == IDLE;
            awvalid_q    <= state_d == WADDR;
            arvalid_q    <= state_d == RADDR;
            bready_q     <= state_d == WRESP;
            done_valid_q <= state_d == DONE;
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// tb_axi_master: randomized scoreboard bench with a behavioural AXI3 slave
module tb_axi_master;

    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;

    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [3:0]  cmd_id = 0, cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [31:0] wr_data = 0;
    logic [3:0]  wr_strb = 0;
    logic        rd_valid, rd_ready = 0, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        done_valid, done_write;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, awcache, arid, arlen, arcache, wid;
    logic [31:0] awaddr, araddr, wdata, rdata = 0;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, awlock, arburst, arlock;
    logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
    logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
    logic [3:0]  wstrb, bid = 0, rid = 0;
    logic [1:0]  bresp = 0, rresp = 0;

    axi_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
        .done_valid(done_valid), .done_write(done_write), .done_id(done_id), .done_resp(done_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {logic [31:0] a; logic [3:0] id; logic [3:0] len;} ax_t;
    typedef struct packed {logic [31:0] d; logic [3:0] s; logic l; logic [3:0] id;} wbeat_t;
    typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} rbeat_t;
    typedef struct packed {logic w; logic [3:0] id; logic [1:0] r;} done_t;

    ax_t    exp_aw[$], exp_ar[$];
    wbeat_t exp_w[$], wr_q[$];
    rbeat_t exp_rd[$];
    done_t  exp_done[$];

    int checks = 0, fails = 0, n_done = 0, w_seen = 0;

    int          cfg_aw_delay, cfg_wmode, cfg_rlast_at;
    bit          cfg_bid_err;
    logic [3:0]  cfg_bid;
    logic [1:0]  cfg_bresp;
    logic [31:0] cfg_wdata[16], cfg_rdata[16];
    logic [3:0]  cfg_wstrb[16];
    logic [1:0]  cfg_rresp[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm, input logic [63:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got unexpected %0h expected nothing", nm, act);
    endtask

    task automatic cfg_default;
        cfg_aw_delay = 0;
        cfg_wmode    = 0;
        cfg_bresp    = 2'b00;
        cfg_bid_err  = 0;
        cfg_rlast_at = -2;
        for (int i = 0; i < 16; i++) begin
            cfg_wdata[i] = $urandom;
            cfg_wstrb[i] = 4'($urandom);
            cfg_rdata[i] = $urandom;
            cfg_rresp[i] = 2'b00;
        end
    endtask

    // Builds the expected responses from the transaction rules, then hands the command over
    task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
        bit got = 0;
        if (cfg_rlast_at == -2) cfg_rlast_at = int'(len);
        cfg_bid = cfg_bid_err ? id ^ 4'h3 : id;
        if (w) begin
            for (int i = 0; i <= int'(len); i++) begin
                wbeat_t b;
                b = '{d: cfg_wdata[i], s: cfg_wstrb[i], l: (i == int'(len)), id: id};
                exp_w.push_back(b);
                wr_q.push_back(b);
            end
            exp_aw.push_back('{a: a, id: id, len: len});
            exp_done.push_back('{w: 1'b1, id: id, r: (cfg_bid != id) ? 2'b10 : cfg_bresp});
        end else begin
            int stop;
            logic [1:0] worst = 2'b00;
            stop = (cfg_rlast_at >= 0 && cfg_rlast_at < int'(len)) ? cfg_rlast_at : int'(len);
            for (int i = 0; i <= stop; i++) begin
                exp_rd.push_back('{d: cfg_rdata[i], r: cfg_rresp[i], l: (i == cfg_rlast_at)});
                if (cfg_rresp[i] > worst) worst = cfg_rresp[i];
            end
            if (cfg_rlast_at != int'(len)) worst = 2'b10;
            exp_ar.push_back('{a: a, id: id, len: len});
            exp_done.push_back('{w: 1'b0, id: id, r: worst});
        end
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_id = id; cmd_len = len;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
        end
        if (!got) chk("cmd_ready_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        chk("axvalid_latency", w ? awvalid : arvalid, 1);
    endtask

    task automatic wait_done;
        int n0 = n_done;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            if (n_done != n0) return;
        end
        chk("done_timeout", n_done - n0, 1);
    endtask

    // Behavioural AXI3 slave: samples handshakes at negedge, drives just after posedge
    initial begin : slave
        bit aw_h, w_h, wl, b_h, ar_h, r_h, b_pend = 0, r_act = 0, tog = 0;
        int aw_cnt = 0, r_idx = 0;
        logic [3:0] r_len = 0, r_id = 0;
        forever begin
            @(negedge clk);
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            wl   = wlast;
            b_h  = bvalid && bready;
            ar_h = arvalid && arready;
            r_h  = rvalid && rready;
            if (awvalid && !awready) aw_cnt++;
            if (ar_h) begin r_len = arlen; r_id = arid; r_idx = 0; r_act = 1; end
            @(posedge clk); #1;
            if (!reset) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rd_ready = 0;
                b_pend = 0; r_act = 0; aw_cnt = 0;
                continue;
            end
            if (aw_h || !awvalid) aw_cnt = 0;
            if (w_h && wl) b_pend = 1;
            if (b_h) b_pend = 0;
            awready = awvalid && aw_cnt >= cfg_aw_delay;
            tog = ~tog;
            wready = (cfg_wmode == 0) ? 1'b1 : (cfg_wmode == 1) ? tog : 1'($urandom_range(0, 1));
            bvalid = b_pend;
            bid = cfg_bid;
            bresp = cfg_bresp;
            arready = arvalid && ($urandom_range(0, 1) == 1);
            if (r_h) begin
                if (r_idx == cfg_rlast_at || r_idx == int'(r_len)) r_act = 0;
                else r_idx++;
            end
            if (!r_act) rvalid = 0;
            else if (!rvalid || r_h) rvalid = ($urandom_range(0, 3) != 0);
            rdata = cfg_rdata[r_idx];
            rresp = cfg_rresp[r_idx];
            rlast = (r_idx == cfg_rlast_at);
            rid = r_id;
            rd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Write-data stream source: holds each beat until accepted
    initial begin : wdrv
        bit hs;
        forever begin
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (!reset) begin wr_q.delete(); wr_valid = 0; continue; end
            if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() == 0) wr_valid = 0;
            else if (!wr_valid || hs) wr_valid = ($urandom_range(0, 3) != 0);
            if (wr_q.size() > 0) begin wr_data = wr_q[0].d; wr_strb = wr_q[0].s; end
        end
    end

    // Monitor: compares every observed handshake with the scoreboard queues
    initial begin : mon
        bit prev_done = 0, aw_hold = 0, ar_hold = 0;
        ax_t aw_s, ar_s, e;
        forever begin
            @(negedge clk);
            if (!reset) begin prev_done = 0; aw_hold = 0; ar_hold = 0; continue; end
            if (prev_done) begin
                chk("done_one_cycle", done_valid, 0);
                chk("cmd_ready_after_done", cmd_ready, 1);
            end
            prev_done = done_valid;
            if (done_valid) begin
                n_done++;
                if (exp_done.size() == 0) miss("done_extra", {done_write, done_id, done_resp});
                else chk("done", {done_write, done_id, done_resp}, exp_done.pop_front());
            end
            if (awvalid && aw_hold) chk("aw_stable", {awaddr, awid, awlen}, aw_s);
            aw_s = '{a: awaddr, id: awid, len: awlen};
            aw_hold = awvalid && !awready;
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) miss("aw_extra", awaddr);
                else chk("aw", {awaddr, awid, awlen}, exp_aw.pop_front());
                chk("aw_attr", {awsize, awburst, awlock, awcache, awprot}, {3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
            end
            if (arvalid && ar_hold) chk("ar_stable", {araddr, arid, arlen}, ar_s);
            ar_s = '{a: araddr, id: arid, len: arlen};
            ar_hold = arvalid && !arready;
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) miss("ar_extra", araddr);
                else begin
                    e = exp_ar.pop_front();
                    chk("ar", {araddr, arid, arlen}, e);
                end
                chk("ar_attr", {arsize, arburst, arlock, arcache, arprot}, {3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
            end
            if (wvalid && wready) begin
                w_seen++;
                if (exp_w.size() == 0) miss("w_extra", wdata);
                else chk("w_beat", {wdata, wstrb, wlast, wid}, exp_w.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) miss("rd_extra", rd_data);
                else chk("rd_beat", {rd_data, rd_resp, rd_last}, exp_rd.pop_front());
            end
        end
    end

    initial begin : stim
        int w0;
        bit w;
        logic [3:0] len, id;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, done_valid, wr_ready, rd_valid}, 0);
        #1 reset = 1;
        @(posedge clk); #1;
        chk("cmd_ready_after_release", cmd_ready, 1);

        cfg_default();
        cfg_wdata[0] = 32'h11; cfg_wdata[1] = 32'h22; cfg_wdata[2] = 32'h33; cfg_wdata[3] = 32'h44;
        for (int i = 0; i < 4; i++) cfg_wstrb[i] = 4'hF;
        w0 = w_seen;
        issue(1, 32'h100, 4'd5, 4'd3);
        wait_done();
        chk("write4_beats", w_seen - w0, 4);

        cfg_default();
        cfg_rdata[0] = 32'hDEADBEEF;
        issue(0, 32'h200, 4'd2, 4'd0);
        wait_done();

        cfg_default();
        cfg_aw_delay = 5;
        cfg_wmode = 1;
        w0 = w_seen;
        issue(1, 32'h140, 4'd5, 4'd3);
        wait_done();
        chk("backpressure_beats", w_seen - w0, 4);

        cfg_default();
        cfg_rresp[1] = 2'b10;
        issue(0, 32'h400, 4'd7, 4'd3);
        wait_done();

        cfg_default();
        cfg_bid_err = 1;
        issue(1, 32'h500, 4'd5, 4'd1);
        wait_done();

        cfg_default();
        cfg_rlast_at = 1;
        issue(0, 32'h600, 4'd3, 4'd3);
        wait_done();

        cfg_default();
        cfg_rlast_at = -1;
        issue(0, 32'h700, 4'd4, 4'd2);
        wait_done();

        cfg_default();
        w0 = w_seen;
        issue(1, 32'h800, 4'd1, 4'd0);
        wait_done();
        chk("len0_write_beats", w_seen - w0, 1);

        for (int n = 0; n < 30; n++) begin
            cfg_default();
            w = 1'($urandom);
            len = 4'($urandom);
            id = 4'($urandom);
            cfg_aw_delay = $urandom_range(0, 3);
            cfg_wmode = $urandom_range(0, 2);
            cfg_bresp = 2'($urandom);
            cfg_bid_err = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 16; i++) cfg_rresp[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 4) == 0) cfg_rlast_at = $urandom_range(0, 16) - 1;
            issue(w, {$urandom_range(0, 255), 2'b00}, id, len);
            wait_done();
        end

        cfg_default();
        w0 = w_seen;
        issue(1, 32'h900, 4'd9, 4'd3);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (w_seen != w0) break;
        end
        chk("rst_in_beat2", w_seen - w0, 1);
        #2 reset = 0;
        #1;
        chk("rst_abort_outputs", {awvalid, wvalid, bready, arvalid, rready, done_valid, cmd_ready, wr_ready}, 0);
        exp_w.delete(); exp_aw.delete(); exp_done.delete(); wr_q.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        repeat (5) @(posedge clk);
        chk("rst_no_more_beats", w_seen - w0, 1);
        cfg_default();
        issue(1, 32'hA00, 4'd6, 4'd2);
        wait_done();
        cfg_default();
        issue(0, 32'hB00, 4'd6, 4'd2);
        wait_done();

        repeat (5) @(posedge clk);
        chk("exp_w_empty", exp_w.size(), 0);
        chk("exp_rd_empty", exp_rd.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);
        chk("exp_ax_empty", exp_aw.size() + exp_ar.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
